// File: rtl/mem_port_arbiter_if.sv
// Requester-side handshake and grant signals of the shared memory port arbiter.
// The arbiter uses the slave modport; the requester/resource side uses master.
interface mem_port_arbiter_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  modport master (
    output req,
    output done,
    input  gnt,
    input  sel,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output sel,
    output busy,
    output timeout
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Four-way round-robin arbiter for a shared memory port: one grant at a time,
// no preemption, a one-cycle release gap and an optional hold-time limit.
module mem_port_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.slave  bus
);

  localparam int unsigned    CntW     = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CntW-1:0] HoldLast = CntW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

  state_e          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [1:0]      sel_q, sel_d;
  logic [3:0]      gnt_q, gnt_d;
  logic [CntW-1:0] hold_q, hold_d;
  logic            timeout_q, timeout_d;

  logic       found;
  logic [1:0] winner;
  logic [1:0] idx;
  logic       hit_limit;
  logic       aborted;

  // Rotating priority scan starting at ptr_q.
  always_comb begin
    found  = 1'b0;
    winner = ptr_q;
    idx    = '0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && bus.req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign hit_limit = (MAX_HOLD != 0) && (hold_q == HoldLast);
  assign aborted   = !bus.req[sel_q];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    gnt_d     = gnt_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StGrant;
          gnt_d   = 4'b0001 << winner;
          sel_d   = winner;
          hold_d  = '0;
        end else begin
          gnt_d = '0;
        end
      end
      StGrant: begin
        if (bus.done || aborted || hit_limit) begin
          state_d   = StRelease;
          gnt_d     = '0;
          ptr_d     = sel_q + 2'd1;
          // Only a pure hold-limit release is reported as a timeout.
          timeout_d = hit_limit && !bus.done && !aborted;
        end else if (hold_q != '1) begin
          hold_d = hold_q + CntW'(1);
        end
      end
      StRelease: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      sel_q     <= '0;
      gnt_q     <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      gnt_q     <= gnt_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.sel     = sel_q;
  assign bus.busy    = (state_q != StIdle);
  assign bus.timeout = timeout_q;

endmodule
